fifo_frame_reader: RTL and testbench

Drain-side companion to the sample FIFOs in the noise-cancelling datapath. Pops samples from a show-ahead FIFO read port (data/empty/rd_ce/error), groups them into frames of FRAME_LEN samples, and presents them to a downstream filter stage over a valid/ready stream with first/last markers. Owns all read-side flow control, so the FIFO is never popped while empty and no sample is dropped under back-pressure.

---
 rtl/fifo_frame_reader_pkg.sv | 14 +
 rtl/fifo_frame_reader_out.sv | 43 ++++
 rtl/fifo_frame_reader.sv | 134 +++++++++++++
 tb/tb_fifo_frame_reader.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_frame_reader_pkg.sv
// Shared definitions for the sample FIFO family.
// Holds the read-FSM state encoding and datapath size defaults.
package fifo_frame_reader_pkg;

    localparam int DWIDTH_DEF    = 32;
    localparam int FRAME_LEN_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_frame_reader_out.sv
// One-entry valid/ready output register for the frame reader.
// Ports: clk, n_rst (sync, active-low), load_i/data_i from the FIFO pop,
// ready_i from downstream, data_o/valid_o to downstream.
module stream_out_reg #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              load_i,
    input  logic              ready_i,
    input  logic [DWIDTH-1:0] data_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o
);

    logic [DWIDTH-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    // A load overrides an accept in the same cycle, so back-to-back
    // pop+accept keeps the stream full.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~ready_i;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains a show-ahead FIFO into FRAME_LEN-sample frames on a valid/ready
// stream. Ports: clk, n_rst (sync, active-low), start/cont/stop control,
// fifo_data/fifo_empty/fifo_error/fifo_rd_ce FIFO read side,
// m_data/m_valid/m_ready/m_first/m_last stream, frame_done/busy/err status.
module fifo_frame_reader
    import fifo_frame_reader_pkg::*;
#(
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_W     = 7
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              cont,
    input  logic              stop,
    input  logic [DWIDTH-1:0] fifo_data,
    input  logic              fifo_empty,
    input  logic              fifo_error,
    output logic              fifo_rd_ce,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_first,
    output logic              m_last,
    output logic              frame_done,
    output logic              busy,
    output logic              err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] pops_q, pops_d;
    logic             cont_q, cont_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic pop;
    logic accept;
    logic last_acc;

    // Gated by n_rst so nothing is popped while reset is held.
    assign pop = n_rst & (state_q == ST_RUN) & ~fifo_empty
               & (~m_valid | m_ready) & (pops_q < FULL_CNT);
    assign accept   = m_valid & m_ready;
    assign last_acc = accept & (idx_q == LAST_IDX);

    stream_out_reg #(
        .DWIDTH(DWIDTH)
    ) u_out (
        .clk    (clk),
        .n_rst  (n_rst),
        .load_i (pop),
        .ready_i(m_ready),
        .data_i (fifo_data),
        .data_o (m_data),
        .valid_o(m_valid)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pops_d  = pops_q;
        cont_d  = cont_q & ~stop;
        err_d   = err_q | ((state_q != ST_IDLE) & fifo_error);
        done_d  = 1'b0;

        if (pop) begin
            pops_d = pops_q + ONE;
        end
        if (accept && idx_q != LAST_IDX) begin
            idx_d = idx_q + ONE;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    pops_d  = '0;
                    cont_d  = cont & ~stop;
                end
            end
            ST_RUN: begin
                if (pop && pops_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The final sample is always accepted here: its pop
                // already moved the FSM out of RUN.
                if (last_acc) begin
                    done_d  = 1'b1;
                    idx_d   = '0;
                    pops_d  = '0;
                    state_d = cont_d ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pops_q  <= '0;
            cont_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pops_q  <= pops_d;
            cont_q  <= cont_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign fifo_rd_ce = pop;
    assign m_first    = m_valid & (idx_q == '0);
    assign m_last     = m_valid & (idx_q == LAST_IDX);
    assign frame_done = done_q;
    assign busy       = (state_q != ST_IDLE);
    assign err        = err_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Self-checking bench for fifo_frame_reader.
// Bench-side FIFO model, stream scoreboard and per-scenario tasks.
module tb_fifo_frame_reader;

    localparam int DW = 32;
    localparam int FL = 64;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic          cont = 1'b0;
    logic          stop = 1'b0;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_error = 1'b0;
    logic          m_ready = 1'b0;
    logic          fifo_rd_ce;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_first;
    logic          m_last;
    logic          frame_done;
    logic          busy;
    logic          err;

    fifo_frame_reader #(
        .DWIDTH(DW), .FRAME_LEN(FL), .CNT_W(CW)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .cont(cont),
        .stop(stop), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_error(fifo_error), .fifo_rd_ce(fifo_rd_ce),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_first(m_first), .m_last(m_last), .frame_done(frame_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // FIFO storage: written by tests, drained by the model below.
    logic [DW-1:0] mem [0:1023];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    int            pop_cnt = 0;

    // Scoreboard state, owned by the clocked model.
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] acc_mem [0:1023];
    int            acc_cnt = 0;
    int            k = 0;
    bit            done_exp = 0;
    bit            stall_prev = 0;
    logic [DW-1:0] data_prev = '0;
    int            done_cnt = 0;
    int            mon_viol = 0;

    logic [DW-1:0] wl [$];

    always @(posedge clk) begin
        done_exp = 1'b0;
        if (!n_rst) begin
            exp_q.delete();
            k = 0;
        end else if (m_valid && m_ready) begin
            acc_mem[acc_cnt] = m_data;
            acc_cnt++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            done_exp = (k % FL == FL - 1);
            k++;
        end
        stall_prev = n_rst && m_valid && !m_ready;
        data_prev = m_data;
        if (fifo_rd_ce && !fifo_empty) begin
            exp_q.push_back(mem[rd_ptr]);
            rd_ptr++;
            pop_cnt++;
        end
        fifo_empty <= (rd_ptr == wr_ptr);
        fifo_data <= mem[rd_ptr];
    end

    always @(negedge clk) begin
        #1;
        if (frame_done) done_cnt++;
        if (fifo_rd_ce && (fifo_empty || (m_valid && !m_ready) || !n_rst)) begin
            mon_viol++;
            $display("FAIL rd_ce_guard: rd_ce=1 empty=%b valid=%b ready=%b n_rst=%b want rd_ce=0",
                     fifo_empty, m_valid, m_ready, n_rst);
        end
        if (frame_done !== done_exp) begin
            mon_viol++;
            $display("FAIL frame_done: got %b want %b", frame_done, done_exp);
        end
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                mon_viol++;
                $display("FAIL m_valid: got 1 with no popped sample, want 0");
            end else if (m_data !== exp_q[0]) begin
                mon_viol++;
                $display("FAIL m_data: got %h want %h", m_data, exp_q[0]);
            end
            if (m_first !== (k % FL == 0) || m_last !== (k % FL == FL - 1)) begin
                mon_viol++;
                $display("FAIL markers: sample %0d first=%b last=%b want %b %b",
                         k, m_first, m_last, (k % FL == 0), (k % FL == FL - 1));
            end
        end else if (m_first || m_last) begin
            mon_viol++;
            $display("FAIL markers_idle: first=%b last=%b want 0 0", m_first, m_last);
        end
        if (stall_prev && (m_valid !== 1'b1 || m_data !== data_prev)) begin
            mon_viol++;
            $display("FAIL hold: valid=%b data=%h want 1 %h", m_valid, m_data, data_prev);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    function automatic logic rdy(input int mode, input int i);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (i % 2 == 0);
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic pulse_start(input logic c);
        start = 1'b1;
        cont = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        cont = 1'b0;
    endtask

    task automatic run_until_done(input int mode, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            m_ready = rdy(mode, i);
            #2;
            if (frame_done) ok = 1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        #2;
        n_cmp++; if (fifo_rd_ce !== 1'b0) begin n_err++; $display("FAIL rst_rd_ce: got %b want 0", fifo_rd_ce); end
        n_cmp++; if (m_data !== '0) begin n_err++; $display("FAIL rst_m_data: got %h want 0", m_data); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_first !== 1'b0) begin n_err++; $display("FAIL rst_m_first: got %b want 0", m_first); end
        n_cmp++; if (m_last !== 1'b0) begin n_err++; $display("FAIL rst_m_last: got %b want 0", m_last); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", frame_done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
        start = 1'b0;
        n_rst = 1'b1;
        @(negedge clk);
        #2;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_start_ignored: busy %b want 0", busy); end
    endtask

    task automatic test_full_rate();
        int b_acc = acc_cnt, b_pop = pop_cnt, b_done = done_cnt, v0 = mon_viol;
        int run = 0, maxr = 0;
        bit ok = 0;
        for (int i = 1; i <= FL; i++) push(DW'(i));
        repeat (2) @(negedge clk);
        m_ready = 1'b1;
        pulse_start(1'b0);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            #2;
            if (fifo_rd_ce) begin run++; if (run > maxr) maxr = run; end
            else run = 0;
            if (frame_done) ok = 1;
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL full_done: no frame_done in 300 cycles"); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy: got %b want 0", busy); end
        n_cmp++; if (maxr != FL) begin n_err++; $display("FAIL full_rate: pop run %0d want %0d", maxr, FL); end
        n_cmp++; if (pop_cnt - b_pop != FL) begin n_err++; $display("FAIL full_pops: got %0d want %0d", pop_cnt - b_pop, FL); end
        n_cmp++; if (acc_cnt - b_acc != FL) begin n_err++; $display("FAIL full_count: got %0d want %0d", acc_cnt - b_acc, FL); end
        for (int i = 0; i < FL; i++) begin
            n_cmp++;
            if (acc_mem[b_acc + i] !== DW'(i + 1)) begin
                n_err++; $display("FAIL full_data[%0d]: got %0d want %0d", i, acc_mem[b_acc + i], i + 1);
            end
        end
        @(negedge clk);
        n_cmp++; if (done_cnt - b_done != 1) begin n_err++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt - b_done); end
        n_cmp++; if (mon_viol != v0) begin n_err++; $display("FAIL full_stream: %0d violations want 0", mon_viol - v0); end
    endtask

    task automatic test_backpressure();
        int b_acc = acc_cnt, b_pop = pop_cnt, v0 = mon_viol;
        bit ok;
        for (int i = 1; i <= FL; i++) push(DW'(i));
        repeat (2) @(negedge clk);
        m_ready = 1'b1;
        pulse_start(1'b0);
        run_until_done(1, 400, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_done: no frame_done in 400 cycles"); end
        n_cmp++; if (pop_cnt - b_pop != FL) begin n_err++; $display("FAIL bp_pops: got %0d want %0d", pop_cnt - b_pop, FL); end
        for (int i = 0; i < FL; i++) begin
            n_cmp++;
            if (acc_mem[b_acc + i] !== DW'(i + 1)) begin
                n_err++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, acc_mem[b_acc + i], i + 1);
            end
        end
        n_cmp++; if (mon_viol != v0) begin n_err++; $display("FAIL bp_stream: %0d violations want 0", mon_viol - v0); end
    endtask

    task automatic test_empty_gaps();
        int b_acc = acc_cnt, b_pop = pop_cnt, v0 = mon_viol;
        logic [DW-1:0] w;
        bit ok;
        wl.delete();
        pulse_start(1'b0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            m_ready = rdy(2, i);
            if (i == 10 || i == 20 || i == 21) begin
                w = $urandom;
                push(w);
                wl.push_back(w);
            end
        end
        for (int i = 0; i < 6; i++) begin @(negedge clk); m_ready = 1'b1; end
        #2;
        n_cmp++; if (pop_cnt - b_pop != 3) begin n_err++; $display("FAIL gap_pops: got %0d want 3", pop_cnt - b_pop); end
        n_cmp++; if (acc_cnt - b_acc != 3) begin n_err++; $display("FAIL gap_count: got %0d want 3", acc_cnt - b_acc); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL gap_busy: got %b want 1", busy); end
        for (int i = 3; i < FL; i++) begin w = $urandom; push(w); wl.push_back(w); end
        run_until_done(2, 600, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL gap_done: no frame_done in 600 cycles"); end
        for (int i = 0; i < FL; i++) begin
            n_cmp++;
            if (acc_mem[b_acc + i] !== wl[i]) begin
                n_err++; $display("FAIL gap_data[%0d]: got %h want %h", i, acc_mem[b_acc + i], wl[i]);
            end
        end
        n_cmp++; if (mon_viol != v0) begin n_err++; $display("FAIL gap_stream: %0d violations want 0", mon_viol - v0); end
    endtask

    task automatic test_continuous();
        int b_acc = acc_cnt, v0 = mon_viol, nd = 0;
        bit stopped = 0;
        for (int i = 1; i <= 2 * FL; i++) push(DW'(i));
        repeat (2) @(negedge clk);
        pulse_start(1'b1);
        for (int i = 0; i < 1200 && nd < 2; i++) begin
            @(negedge clk);
            m_ready = rdy(2, i);
            stop = !stopped && (acc_cnt - b_acc >= 80);
            if (stop) stopped = 1;
            #2;
            if (frame_done) begin
                nd++;
                if (nd == 1) begin
                    n_cmp++;
                    if (fifo_rd_ce !== 1'b1) begin n_err++; $display("FAIL cont_rearm: rd_ce %b at frame_done want 1", fifo_rd_ce); end
                end else begin
                    n_cmp++;
                    if (busy !== 1'b0) begin n_err++; $display("FAIL cont_stop: busy %b after stop want 0", busy); end
                end
            end
        end
        stop = 1'b0;
        n_cmp++; if (nd != 2) begin n_err++; $display("FAIL cont_frames: got %0d want 2", nd); end
        for (int i = 0; i < 2 * FL; i++) begin
            n_cmp++;
            if (acc_mem[b_acc + i] !== DW'(i + 1)) begin
                n_err++; $display("FAIL cont_data[%0d]: got %0d want %0d", i, acc_mem[b_acc + i], i + 1);
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cont_idle: busy %b want 0", busy); end
        end
        n_cmp++; if (mon_viol != v0) begin n_err++; $display("FAIL cont_stream: %0d violations want 0", mon_viol - v0); end
    endtask

    task automatic test_error();
        int b_acc = acc_cnt, v0 = mon_viol;
        logic [DW-1:0] w;
        bit ok;
        wl.delete();
        fifo_error = 1'b1;
        @(negedge clk);
        fifo_error = 1'b0;
        @(negedge clk);
        #2;
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_idle: got %b want 0", err); end
        for (int i = 0; i < FL; i++) begin w = $urandom; push(w); wl.push_back(w); end
        repeat (2) @(negedge clk);
        pulse_start(1'b0);
        for (int i = 0; i < 20; i++) begin @(negedge clk); m_ready = rdy(2, i); end
        fifo_error = 1'b1;
        @(negedge clk);
        fifo_error = 1'b0;
        #2;
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", err); end
        run_until_done(2, 600, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL err_done: no frame_done in 600 cycles"); end
        @(negedge clk);
        #2;
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err); end
        for (int i = 0; i < FL; i++) begin
            n_cmp++;
            if (acc_mem[b_acc + i] !== wl[i]) begin
                n_err++; $display("FAIL err_data[%0d]: got %h want %h", i, acc_mem[b_acc + i], wl[i]);
            end
        end
        n_cmp++; if (mon_viol != v0) begin n_err++; $display("FAIL err_stream: %0d violations want 0", mon_viol - v0); end
    endtask

    task automatic test_reset_mid();
        int b_acc = acc_cnt, v0 = mon_viol, rp;
        logic [DW-1:0] w;
        bit ok;
        for (int i = 0; i < 100; i++) begin w = $urandom; push(w); end
        repeat (2) @(negedge clk);
        m_ready = 1'b1;
        pulse_start(1'b0);
        for (int i = 0; i < 200 && acc_cnt - b_acc < 30; i++) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        #2;
        n_cmp++; if (fifo_rd_ce !== 1'b0) begin n_err++; $display("FAIL mid_rd_ce: got %b want 0", fifo_rd_ce); end
        n_cmp++; if (m_data !== '0) begin n_err++; $display("FAIL mid_m_data: got %h want 0", m_data); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_first !== 1'b0 || m_last !== 1'b0) begin n_err++; $display("FAIL mid_markers: got %b%b want 00", m_first, m_last); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL mid_err: got %b want 0", err); end
        n_rst = 1'b1;
        @(negedge clk);
        rp = rd_ptr;
        b_acc = acc_cnt;
        pulse_start(1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        n_cmp++;
        if (m_valid !== 1'b1 || m_first !== 1'b1 || m_data !== mem[rp]) begin
            n_err++;
            $display("FAIL mid_restart: valid=%b first=%b data=%h want 1 1 %h", m_valid, m_first, m_data, mem[rp]);
        end
        run_until_done(0, 300, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL mid_done: no frame_done in 300 cycles"); end
        for (int i = 0; i < FL; i++) begin
            n_cmp++;
            if (acc_mem[b_acc + i] !== mem[rp + i]) begin
                n_err++; $display("FAIL mid_data[%0d]: got %h want %h", i, acc_mem[b_acc + i], mem[rp + i]);
            end
        end
        n_cmp++; if (mon_viol != v0) begin n_err++; $display("FAIL mid_stream: %0d violations want 0", mon_viol - v0); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_full_rate();
        test_backpressure();
        test_empty_gaps();
        test_continuous();
        test_error();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
